// File: rtl/tt_seg7_pkg.sv
// -----------------------------------------------------------------------------
// tt_seg7_pkg
// Shared definitions for the two-digit multiplexed 7-segment scan stage.
//
// Contents:
//   state_e     : scan FSM states (low digit, dead time, high digit, dead time)
//   SEG_OFF     : active-high "all segments dark" pattern
//   HEX_TABLE   : 16-entry nibble -> {g,f,e,d,c,b,a} lookup, active-high
//   hex_to_seg  : lookup helper used by the decoder sub-module
// -----------------------------------------------------------------------------
package tt_seg7_pkg;

  // The scan alternates between the two digits, with a blanking interval in
  // between so the previous digit's segments never bleed into the next one.
  typedef enum logic [1:0] {
    SHOW_LO = 2'd0,
    DEAD_LH = 2'd1,
    SHOW_HI = 2'd2,
    DEAD_HL = 2'd3
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index 15 is the leftmost element, so the table reads F down to 0.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/tt_hex7seg.sv
// -----------------------------------------------------------------------------
// tt_hex7seg
// Purely combinational hex digit decoder, active-high segment outputs.
//
// Ports:
//   nibble_i  in  4  hex digit to display
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, bit0 = a, 1 = lit
// -----------------------------------------------------------------------------
module tt_hex7seg
  import tt_seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup; polarity and blanking are handled by the caller.
  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/tt_seg7_scan.sv
// -----------------------------------------------------------------------------
// tt_seg7_scan
// Two-digit multiplexed hex 7-segment driver for the 8-bit counter tile.
// A new counter value is only moved onto the display at a frame boundary, so
// the two digits always belong to the same sample. Dead time between digits
// suppresses ghosting, and a PWM gate on the segments sets brightness.
// The decimal point on the high digit flags terminal count (0xFF).
//
// Parameters:
//   PRESCALE_W    digit dwell = 2^PRESCALE_W cycles (3..16)
//   DEAD_CYC      blank cycles between digits (1 .. 2^PRESCALE_W-1)
//   COMMON_ANODE  1 = seg, dp and dig pins are active-low
//
// Ports:
//   clk        in   1  clock, all state on posedge
//   rst        in   1  asynchronous reset, active-high
//   ena        in   1  tile enable; low freezes scan and outputs
//   cnt_in     in   8  counter value from upstream
//   cnt_valid  in   1  one-cycle strobe qualifying cnt_in
//   bright     in   3  brightness, duty = (bright+1)/8
//   seg        out  7  segments {g,f,e,d,c,b,a}, bit0 = a
//   dp         out  1  decimal point (terminal count warning)
//   dig        out  2  one-hot digit select, dig[0] = low nibble
//   frame      out  1  one-cycle pulse per completed frame
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, a zero high nibble is shown
//                               dark (digit select and timing unchanged).
// -----------------------------------------------------------------------------
module tt_seg7_scan
  import tt_seg7_pkg::*;
#(
  parameter int PRESCALE_W   = 10,
  parameter int DEAD_CYC     = 4,
  parameter int COMMON_ANODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] cnt_in,
  input  logic       cnt_valid,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig,
  output logic       frame
);

  localparam logic [PRESCALE_W-1:0] SHOW_LAST = '1;
  localparam logic [PRESCALE_W-1:0] DEAD_LAST = PRESCALE_W'(DEAD_CYC - 1);

  // Polarity masks: the output registers hold pin-level values, so the
  // inactive reset value of each pin is simply its mask.
  localparam logic [6:0] SEG_POL = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_POL  = (COMMON_ANODE != 0);
  localparam logic [1:0] DIG_POL = (COMMON_ANODE != 0) ? 2'b11 : 2'b00;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] tmr_q, tmr_d;
  logic [7:0]            disp_q, disp_d;
  logic [7:0]            pend_q, pend_d;
  logic                  pendFlag_q, pendFlag_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [1:0]            dig_q, dig_d;
  logic                  frame_q, frame_d;

  logic                  frameLoad;
  logic [3:0]            shownNibble;
  logic [6:0]            hexSeg;
  logic                  pwmOn;
  logic [6:0]            segAct;
  logic                  dpAct;
  logic [1:0]            digAct;

  // Scan FSM next state. The timer only advances while enabled, which is what
  // stretches a dwell when the tile is paused. Each state exit clears the
  // timer, and leaving the trailing dead time marks the frame boundary.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    frameLoad = 1'b0;
    if (ena) begin
      tmr_d = tmr_q + 1'b1;
      unique case (state_q)
        SHOW_LO: begin
          if (tmr_q == SHOW_LAST) begin
            state_d = DEAD_LH;
            tmr_d   = '0;
          end
        end
        DEAD_LH: begin
          if (tmr_q == DEAD_LAST) begin
            state_d = SHOW_HI;
            tmr_d   = '0;
          end
        end
        SHOW_HI: begin
          if (tmr_q == SHOW_LAST) begin
            state_d = DEAD_HL;
            tmr_d   = '0;
          end
        end
        DEAD_HL: begin
          if (tmr_q == DEAD_LAST) begin
            state_d   = SHOW_LO;
            tmr_d     = '0;
            frameLoad = 1'b1;
          end
        end
        default: begin
          state_d = SHOW_LO;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Capture and frame load. Strobes are buffered in pend regardless of ena,
  // the latest one overwriting any earlier unconsumed value. At the frame
  // boundary a strobe arriving in that very cycle goes straight to the
  // display, otherwise any buffered value is moved across.
  always_comb begin
    pend_d     = pend_q;
    pendFlag_d = pendFlag_q;
    disp_d     = disp_q;
    if (cnt_valid) begin
      pend_d     = cnt_in;
      pendFlag_d = 1'b1;
    end
    if (frameLoad) begin
      if (cnt_valid) begin
        disp_d     = cnt_in;
        pendFlag_d = 1'b0;
      end else if (pendFlag_q) begin
        disp_d     = pend_q;
        pendFlag_d = 1'b0;
      end
    end
  end

  // One shared decoder: its input follows whichever digit is being scanned.
  assign shownNibble = (state_q == SHOW_HI) ? disp_q[7:4] : disp_q[3:0];

  tt_hex7seg u_hex7seg (
    .nibble_i (shownNibble),
    .seg_o    (hexSeg)
  );

  // The low three timer bits form the PWM phase, so each dwell holds a whole
  // number of 8-cycle PWM periods.
  assign pwmOn = (tmr_q[2:0] <= bright);

  // Active-high output image for the current state and timer. The digit
  // select stays on for the whole dwell; only segments and dp are gated.
  always_comb begin
    segAct = SEG_OFF;
    dpAct  = 1'b0;
    digAct = 2'b00;
    unique case (state_q)
      SHOW_LO: begin
        digAct = 2'b01;
        if (pwmOn) begin
          segAct = hexSeg;
        end
      end
      SHOW_HI: begin
        digAct = 2'b10;
        if (pwmOn) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
          segAct = (disp_q[7:4] == 4'h0) ? SEG_OFF : hexSeg;
`else
          segAct = hexSeg;
`endif
          dpAct  = (disp_q == 8'hFF);
        end
      end
      default: begin
        segAct = SEG_OFF;
        dpAct  = 1'b0;
        digAct = 2'b00;
      end
    endcase
  end

  // Output register inputs at pin polarity. While disabled every pin holds,
  // except frame, which is a pulse and therefore only ever lasts one cycle.
  always_comb begin
    seg_d   = seg_q;
    dp_d    = dp_q;
    dig_d   = dig_q;
    frame_d = frameLoad;
    if (ena) begin
      seg_d = segAct ^ SEG_POL;
      dp_d  = dpAct ^ DP_POL;
      dig_d = digAct ^ DIG_POL;
    end
  end

  // All state, with asynchronous reset to an idle, dark display showing zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SHOW_LO;
      tmr_q      <= '0;
      disp_q     <= 8'h00;
      pend_q     <= 8'h00;
      pendFlag_q <= 1'b0;
      seg_q      <= SEG_POL;
      dp_q       <= DP_POL;
      dig_q      <= DIG_POL;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pendFlag_q <= pendFlag_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
      frame_q    <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_tt_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_tt_seg7_scan
// Self-checking bench for tt_seg7_scan with PRESCALE_W=4, DEAD_CYC=2,
// COMMON_ANODE=0. A frame is 36 cycles: 16 low-digit, 2 dead, 16 high-digit,
// 2 dead, with frame high on the last dead cycle. Each vector record names a
// counter value, a brightness and the hand-decoded segment patterns.
// -----------------------------------------------------------------------------
module tb_tt_seg7_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] cnt_in;
  logic       cnt_valid;
  logic [2:0] bright;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dig;
  logic       frame;

  int testsRun    = 0;
  int testsFailed = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'h00;
`else
  localparam logic [6:0] HI_ZERO = 7'h3F;
`endif

  typedef struct {
    logic [7:0] cnt;
    logic [2:0] br;
    logic [6:0] loSeg;
    logic [6:0] hiSeg;
    logic       dpOn;
  } vec_t;

  vec_t vecs[9];

  tt_seg7_scan #(
    .PRESCALE_W   (4),
    .DEAD_CYC     (2),
    .COMMON_ANODE (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .bright    (bright),
    .seg       (seg),
    .dp        (dp),
    .dig       (dig),
    .frame     (frame)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int pos,
                             input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s pos=%0d got=%h expected=%h", name, pos, act, exp);
    end
  endtask

  // Expected pins at frame position pos for a display showing lo/hi patterns.
  task automatic expectAt(input int pos, input logic [6:0] lo, input logic [6:0] hi,
                          input logic dpOn, input logic [2:0] br,
                          output logic [6:0] eSeg, output logic eDp,
                          output logic [1:0] eDig, output logic eFrame);
    eSeg   = 7'h00;
    eDp    = 1'b0;
    eDig   = 2'b00;
    eFrame = (pos == 35);
    if (pos < 16) begin
      eDig = 2'b01;
      if ((pos % 8) <= int'(br)) eSeg = lo;
    end else if (pos >= 18 && pos < 34) begin
      eDig = 2'b10;
      if (((pos - 18) % 8) <= int'(br)) begin
        eSeg = hi;
        eDp  = dpOn;
      end
    end
  endtask

  task automatic checkAll(input string tag, input int pos, input logic [6:0] eSeg,
                          input logic eDp, input logic [1:0] eDig, input logic eFrame);
    checkOutput({tag, "_seg"},   pos, {1'b0, seg},    {1'b0, eSeg});
    checkOutput({tag, "_dp"},    pos, {7'b0, dp},     {7'b0, eDp});
    checkOutput({tag, "_dig"},   pos, {6'b0, dig},    {6'b0, eDig});
    checkOutput({tag, "_frame"}, pos, {7'b0, frame},  {7'b0, eFrame});
  endtask

  // Run nPos positions of one frame, checking every cycle against the value
  // currently on display. Up to two strobes can be injected at given
  // positions, and an optional freeze of fzLen cycles inserted before
  // position fzi, with a strobe of fzV on its fifth cycle.
  task automatic applyStimulus(input logic [6:0] lo, input logic [6:0] hi,
                               input logic dpOn, input logic [2:0] br,
                               input int s1i, input logic [7:0] s1v,
                               input int s2i, input logic [7:0] s2v,
                               input int fzi, input int fzLen, input logic [7:0] fzV,
                               input int nPos);
    logic [6:0] eSeg;
    logic       eDp;
    logic [1:0] eDig;
    logic       eFrame;
    bright = br;
    for (int i = 0; i < nPos; i++) begin
      if (i == fzi && fzLen > 0) begin
        expectAt(i - 1, lo, hi, dpOn, br, eSeg, eDp, eDig, eFrame);
        ena = 1'b0;
        for (int k = 0; k < fzLen; k++) begin
          cnt_valid = (k == 4);
          cnt_in    = fzV;
          step();
          checkAll("freeze", i, eSeg, eDp, eDig, 1'b0);
        end
        cnt_valid = 1'b0;
        ena       = 1'b1;
      end
      cnt_valid = (i == s1i) || (i == s2i);
      cnt_in    = (i == s2i) ? s2v : s1v;
      step();
      expectAt(i, lo, hi, dpOn, br, eSeg, eDp, eDig, eFrame);
      checkAll("scan", i, eSeg, eDp, eDig, eFrame);
    end
    cnt_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] prevLo;
    logic [6:0] prevHi;
    logic       prevDp;
    logic [2:0] prevBr;

    vecs[0] = '{8'h5A, 3'd7, 7'h77, 7'h6D, 1'b0};
    vecs[1] = '{8'hFF, 3'd3, 7'h71, 7'h71, 1'b1};
    vecs[2] = '{8'hFE, 3'd0, 7'h79, 7'h71, 1'b0};
    vecs[3] = '{8'h12, 3'd7, 7'h5B, 7'h06, 1'b0};
    vecs[4] = '{8'h09, 3'd5, 7'h6F, HI_ZERO, 1'b0};
    vecs[5] = '{8'hC4, 3'd1, 7'h66, 7'h39, 1'b0};
    vecs[6] = '{8'h3B, 3'd2, 7'h7C, 7'h4F, 1'b0};
    vecs[7] = '{8'h87, 3'd6, 7'h07, 7'h7F, 1'b0};
    vecs[8] = '{8'h6D, 3'd4, 7'h5E, 7'h7D, 1'b0};

    rst       = 1'b1;
    ena       = 1'b1;
    cnt_valid = 1'b0;
    cnt_in    = 8'h00;
    bright    = 3'd7;

    // Held in reset: display dark, no frame pulse.
    repeat (3) step();
    checkAll("reset", 0, 7'h00, 1'b0, 2'b00, 1'b0);
    rst = 1'b0;

    // First frame shows 00; each later frame shows the value strobed
    // mid-low-digit of the frame before, so every strobe is also a
    // tear-free check on the frame it lands in.
    prevLo = 7'h3F;
    prevHi = HI_ZERO;
    prevDp = 1'b0;
    prevBr = 3'd7;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(prevLo, prevHi, prevDp, prevBr, 7, vecs[k].cnt, -1, 8'h00,
                    -1, 0, 8'h00, 36);
      prevLo = vecs[k].loSeg;
      prevHi = vecs[k].hiSeg;
      prevDp = vecs[k].dpOn;
      prevBr = vecs[k].br;
    end

    // Back-to-back strobes: the later one (44) must win.
    applyStimulus(prevLo, prevHi, prevDp, prevBr, 10, 8'h33, 11, 8'h44,
                  -1, 0, 8'h00, 36);
    // Buffered 11 versus a strobe of A5 on the load cycle: bypass wins.
    applyStimulus(7'h66, 7'h66, 1'b0, 3'd7, 10, 8'h11, 35, 8'hA5,
                  -1, 0, 8'h00, 36);
    // Freeze 10 cycles inside the high dwell, strobing 3C while frozen.
    applyStimulus(7'h6D, 7'h77, 1'b0, 3'd7, -1, 8'h00, -1, 8'h00,
                  25, 10, 8'h3C, 36);
    // Frozen strobe shows; stop partway through the high digit.
    applyStimulus(7'h39, 7'h4F, 1'b0, 3'd7, -1, 8'h00, -1, 8'h00,
                  -1, 0, 8'h00, 26);

    // Asynchronous reset mid high digit: pins go dark without a clock edge.
    rst = 1'b1;
    #1;
    checkAll("midreset", 26, 7'h00, 1'b0, 2'b00, 1'b0);
    step();
    checkAll("midreset_hold", 26, 7'h00, 1'b0, 2'b00, 1'b0);
    rst = 1'b0;

    // Scan restarts from the low digit with the display cleared to 00.
    applyStimulus(7'h3F, HI_ZERO, 1'b0, 3'd7, -1, 8'h00, -1, 8'h00,
                  -1, 0, 8'h00, 36);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
